// File: rtl/axi_pci_write_frontend.sv
// AXI4 write-channel front end: buffers one W burst, issues a wcmd, and relays the completion on B.
// Latency: AW->wready 1 cycle, last W beat->wcmd_valid 1 cycle, wresp_valid->bvalid 1 cycle.
// Backpressure: one burst outstanding; awready only in IDLE. wcmd and B are held until accepted.
// Optional macro AXI_PCI_WLAST_CHECK_EN turns a wlast/beat-count disagreement into SLVERR.
module axi_pci_write_frontend #(
    parameter int ADDR_WIDTH     = 64,
    parameter int BUF_DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [3:0]            s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [9:0]            wdata_idx,
    output logic [31:0]           wdata_dout,
    output logic [3:0]            wdata_strb,
    output logic [3:0]            wcmd_id,
    output logic [7:0]            wcmd_len,
    output logic [63:0]           wcmd_addr,
    output logic                  wcmd_valid,
    input  logic                  wcmd_ready,
    input  logic [3:0]            wresp_id,
    input  logic [7:0]            wresp_len,
    input  logic [1:0]            wresp_err,
    input  logic                  wresp_valid,
    output logic                  wresp_ready
);
    localparam int DEPTH = 1 << BUF_DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, DATA, DROP, CMD, WAIT, RESP} state_t;

    state_t      state;
    logic [9:0]  wr_ptr;
    logic [7:0]  beat_cnt;
    logic        err;
    logic        dropped;
    logic [35:0] mem [DEPTH];

    logic        w_hs;
    logic        last_beat;
    logic        store;
    logic        unsup;
    logic        wlast_bad;
    logic        unused_ok;

    assign s_axi_awready = (state == IDLE);
    assign w_hs          = s_axi_wvalid & s_axi_wready;
    // The beat counter, not wlast, decides where a burst ends.
    assign last_beat     = (beat_cnt == wcmd_len);
    assign store         = w_hs & (state == DATA);
    assign unsup         = (s_axi_awburst != 2'b01) | (s_axi_awsize != 3'b010);
    // Completion is consumed in the same cycle the B beat is taken; dropped bursts never had one.
    assign wresp_ready   = (state == RESP) & s_axi_bready & ~dropped;

`ifdef AXI_PCI_WLAST_CHECK_EN
    assign wlast_bad = w_hs & (s_axi_wlast != last_beat);
    assign unused_ok = ^{wresp_len, wdata_idx};
`else
    assign wlast_bad = 1'b0;
    assign unused_ok = ^{wresp_len, wdata_idx, s_axi_wlast};
`endif

    // Combinational read for the downstream master; it only reads after the command handshake.
    assign {wdata_strb, wdata_dout} = mem[wdata_idx[BUF_DEPTH_LOG2-1:0]];

    // Buffer storage; contents are not reset, the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (store)
            mem[wr_ptr[BUF_DEPTH_LOG2-1:0]] <= {s_axi_wstrb, s_axi_wdata};
    end

    // Burst sequencing: accept AW, collect/drop beats, issue wcmd, wait completion, return B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            beat_cnt     <= '0;
            err          <= 1'b0;
            dropped      <= 1'b0;
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bid    <= '0;
            s_axi_bresp  <= '0;
            wcmd_valid   <= 1'b0;
            wcmd_id      <= '0;
            wcmd_len     <= '0;
            wcmd_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_awvalid) begin
                        wcmd_id      <= s_axi_awid;
                        wcmd_len     <= s_axi_awlen;
                        wcmd_addr    <= 64'(s_axi_awaddr);
                        beat_cnt     <= '0;
                        err          <= unsup;
                        dropped      <= unsup;
                        s_axi_wready <= 1'b1;
                        state        <= unsup ? DROP : DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        wr_ptr   <= wr_ptr + 10'd1;
                        beat_cnt <= beat_cnt + 8'd1;
                        if (wlast_bad)
                            err <= 1'b1;
                        if (last_beat) begin
                            s_axi_wready <= 1'b0;
                            wcmd_valid   <= 1'b1;
                            state        <= CMD;
                        end
                    end
                end
                DROP: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (last_beat) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= wcmd_id;
                            s_axi_bresp  <= 2'b10;
                            state        <= RESP;
                        end
                    end
                end
                CMD: begin
                    if (wcmd_ready) begin
                        wcmd_valid <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (wresp_valid) begin
                        s_axi_bid    <= wresp_id;
                        s_axi_bresp  <= err ? 2'b10 : wresp_err;
                        s_axi_bvalid <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
